// File: rtl/i2c_byte_ctrl.sv
// i2c_byte_ctrl: byte-level I2C master sequencer (START/STOP/WRITE/READ); optional clock stretching via I2C_CLK_STRETCH_EN
module i2c_byte_ctrl #(
  parameter int QDIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic [7:0] tx_data,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       ack_out,
  output logic       done,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in,
  input  logic       scl_in
);
  localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QDIV - 1);
  typedef enum logic [2:0] {IDLE, START, STOP, DATA, ACK} state_t;
  state_t state, state_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [1:0] q, q_n;
  logic [2:0] bitcnt, bit_n;
  logic [7:0] sh, sh_n, rsh, rsh_n, rx_data_n;
  logic rd, rd_n, rxa, rxa_n, ack_n, done_n, scl_n, sda_n, stall, wrap, samp;
`ifdef I2C_CLK_STRETCH_EN
  assign stall = (state == DATA || state == ACK) && q[1] && !scl_in;
`else
  assign stall = scl_in & 1'b0;
`endif
  assign wrap = !stall && qcnt == QMAX;
  assign samp = !stall && q == 2'd3 && qcnt == '0;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  // next state, counters, shift registers and the registered line levels derived from the next state
  always_comb begin
    state_n = state;
    qcnt_n = qcnt;
    q_n = q;
    bit_n = bitcnt;
    sh_n = sh;
    rsh_n = rsh;
    rd_n = rd;
    rxa_n = rxa;
    rx_data_n = rx_data;
    ack_n = ack_out;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (cmd_valid) begin
        state_n = cmd == 2'b00 ? START : cmd == 2'b01 ? STOP : DATA;
        qcnt_n = '0;
        q_n = 2'd0;
        bit_n = 3'd7;
        sh_n = tx_data;
        rd_n = cmd == 2'b11;
        rxa_n = rx_ack;
      end
    end else begin
      if (!stall) qcnt_n = wrap ? '0 : qcnt + 1'b1;
      if (wrap) q_n = q + 2'd1;
      if (samp && state == DATA && rd) rsh_n = {rsh[6:0], sda_in};
      if (samp && state == ACK && !rd) ack_n = sda_in;
      if (wrap && q == 2'd3) begin
        if (state == DATA) begin
          sh_n = {sh[6:0], 1'b0};
          bit_n = bitcnt - 3'd1;
          state_n = bitcnt == 3'd0 ? ACK : DATA;
        end else begin
          state_n = IDLE;
          done_n = 1'b1;
          if (state == ACK && rd) rx_data_n = rsh;
        end
      end
    end
    scl_n = state_n == START ? q_n == 2'd3 :
            state_n == STOP  ? q_n == 2'd0 :
            state_n == IDLE  ? (state == IDLE ? scl_oe : state != STOP) : !q_n[1];
    sda_n = state_n == START ? q_n[1] :
            state_n == STOP  ? q_n != 2'd3 :
            state_n == DATA  ? !rd_n && !sh_n[7] :
            state_n == ACK   ? rd_n && !rxa_n : (state == IDLE ? sda_oe : state == START);
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      qcnt <= '0;
      q <= 2'd0;
      bitcnt <= 3'd0;
      sh <= 8'h00;
      rsh <= 8'h00;
      rd <= 1'b0;
      rxa <= 1'b0;
      rx_data <= 8'h00;
      ack_out <= 1'b1;
      done <= 1'b0;
      scl_oe <= 1'b0;
      sda_oe <= 1'b0;
    end else begin
      state <= state_n;
      qcnt <= qcnt_n;
      q <= q_n;
      bitcnt <= bit_n;
      sh <= sh_n;
      rsh <= rsh_n;
      rd <= rd_n;
      rxa <= rxa_n;
      rx_data <= rx_data_n;
      ack_out <= ack_n;
      done <= done_n;
      scl_oe <= scl_n;
      sda_oe <= sda_n;
    end
  end
endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// tb_i2c_byte_ctrl: table-driven plus randomized check of i2c_byte_ctrl against a command-level model
module tb_i2c_byte_ctrl;
  localparam int QDIV = 4;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, rx_ack = 1'b0, sda_in = 1'b1, scl_in = 1'b1;
  logic [1:0] cmd = 2'b00;
  logic [7:0] tx_data = 8'h00;
  logic cmd_ready, ack_out, done, busy, scl_oe, sda_oe;
  logic [7:0] rx_data;
  int checks = 0, fails = 0;
  logic [7:0] rx_m = 8'h00;
  logic ack_m = 1'b1;

  typedef struct {
    logic [1:0] c;
    logic [7:0] tx;
    logic ra;
    logic [7:0] sb;
    logic sa;
    bit poke;
    int lat;
    logic [8:0] pat;
    logic [7:0] rx;
    logic ack;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  i2c_byte_ctrl #(.QDIV(QDIV)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .tx_data(tx_data), .rx_ack(rx_ack), .rx_data(rx_data), .ack_out(ack_out), .done(done),
    .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in), .scl_in(scl_in)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model: per-bit/per-quarter line levels straight from the command definitions
  task automatic model(inout vec_t v);
    v.lat = v.c[1] ? 36 * QDIV : 4 * QDIV;
    v.pat = v.c == 2'b00 ? 9'b0_00_00_01_11 :
            v.c == 2'b01 ? 9'b0_11_01_01_00 :
            v.c == 2'b10 ? {~v.tx, 1'b0} : {8'h00, ~v.ra};
    if (v.c == 2'b10) ack_m = v.sa;
    if (v.c == 2'b11) rx_m = v.sb;
    v.rx = rx_m;
    v.ack = ack_m;
  endtask

  // Issue one command, act as the slave, capture line levels, return done latency
  task automatic run(input vec_t v, input int stall_at, output int lat, output logic [8:0] pat);
    cmd_valid = 1'b1;
    cmd = v.c;
    tx_data = v.tx;
    rx_ack = v.ra;
    check("ready_at_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd = 2'($urandom);
    tx_data = 8'($urandom);
    rx_ack = 1'($urandom);
    lat = -1;
    pat = '0;
    for (int j = 0; j < 400 && lat < 0; j++) begin
      int je, k, qi;
      logic lvl;
      if (done) begin
        lat = j;
        check("ready_on_done", 32'(cmd_ready), 32'd1);
      end else begin
        je = j;
`ifdef I2C_CLK_STRETCH_EN
        if (stall_at >= 0 && j > stall_at) je = j - ((j - stall_at) < 20 ? (j - stall_at) : 20);
`endif
        scl_in = !(stall_at >= 0 && j >= stall_at && j < stall_at + 20);
        k = je / 16;
        qi = je / 4;
        if (je % 4 == 1) begin
          if (v.c[1] && je % 16 == 1 && k <= 8) pat[8-k] = sda_oe;
          if (!v.c[1] && qi < 4) begin
            pat[7-2*qi] = scl_oe;
            pat[6-2*qi] = sda_oe;
          end
        end
        lvl = v.c == 2'b10 ? (k == 8 ? v.sa : 1'b1) : (v.c == 2'b11 && k < 8) ? v.sb[7-k] : 1'b1;
        sda_in = lvl & ~sda_oe;
        cmd_valid = v.poke && j == 20;
        cmd = 2'b01;
        @(posedge clk);
        #1;
      end
    end
    cmd_valid = 1'b0;
    scl_in = 1'b1;
    sda_in = 1'b1;
  endtask

  task automatic apply(input string name, input vec_t v, input int stall_at);
    int lat;
    logic [8:0] pat;
    run(v, stall_at, lat, pat);
    check({name, "_latency"}, 32'(lat), 32'(v.lat));
    check({name, "_sda_pattern"}, 32'(pat), 32'(v.pat));
    check({name, "_rx_data"}, 32'(rx_data), 32'(v.rx));
    check({name, "_ack_out"}, 32'(ack_out), 32'(v.ack));
    @(posedge clk);
    #1;
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc;
    vec_t v;
    tbl[0] = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16,  9'h007, 8'h00, 1'b1};
    tbl[1] = '{2'b10, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 144, 9'h0B4, 8'h00, 1'b0};
    tbl[2] = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16,  9'h007, 8'h00, 1'b0};
    tbl[3] = '{2'b11, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b0, 144, 9'h000, 8'h3C, 1'b0};
    tbl[4] = '{2'b01, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16,  9'h0D4, 8'h3C, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_scl_oe", 32'(scl_oe), 32'd0);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_ack_out", 32'(ack_out), 32'd1);
    dc = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) dc++;
    end
    check("idle_done_pulses", 32'(dc), 32'd0);
    check("idle_scl_oe", 32'(scl_oe), 32'd0);
    for (int i = 0; i < 5; i++) begin
      apply($sformatf("vec%0d", i), tbl[i], -1);
      rx_m = tbl[i].rx;
      ack_m = tbl[i].ack;
    end
    cmd_valid = 1'b1;
    cmd = 2'b10;
    tx_data = 8'hFF;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    check("midwrite_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_scl_oe", 32'(scl_oe), 32'd0);
    check("abort_sda_oe", 32'(sda_oe), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    rx_m = 8'h00;
    ack_m = 1'b1;
    v = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 0, 9'h0, 8'h0, 1'b0};
    model(v);
    apply("after_reset_start", v, -1);
    v = '{2'b10, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 0, 9'h0, 8'h0, 1'b0};
    model(v);
`ifdef I2C_CLK_STRETCH_EN
    v.lat = 164;
`endif
    apply("stretch_write", v, 56);
    for (int i = 0; i < 12; i++) begin
      v.c = 2'($urandom_range(0, 3));
      v.tx = 8'($urandom);
      v.ra = 1'($urandom);
      v.sb = 8'($urandom);
      v.sa = 1'($urandom);
      v.poke = 1'($urandom);
      model(v);
      apply($sformatf("rand%0d", i), v, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
